// File: rtl/gpio_irq_pkg.sv
// Shared types, register addresses and address decode for the gpio_irq slot peripheral.
package gpio_irq_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_WO, ACC_W1C} acc_e;

  localparam logic [7:0] ADDR_OUT_DATA   = 8'h00;
  localparam logic [7:0] ADDR_OUT_SET    = 8'h04;
  localparam logic [7:0] ADDR_OUT_CLR    = 8'h08;
  localparam logic [7:0] ADDR_IN_DATA    = 8'h0C;
  localparam logic [7:0] ADDR_IRQ_EN     = 8'h10;
  localparam logic [7:0] ADDR_RISE_EN    = 8'h14;
  localparam logic [7:0] ADDR_FALL_EN    = 8'h18;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h1C;
  localparam logic [7:0] ADDR_DEBOUNCE   = 8'h20;

  typedef struct packed {
    logic mapped;
    acc_e acc;
  } decode_t;

  function automatic decode_t decode_addr(input logic [7:0] a);
    decode_t d;
    d.mapped = 1'b1;
    d.acc    = ACC_RW;
    case (a)
      ADDR_OUT_DATA, ADDR_IRQ_EN, ADDR_RISE_EN,
      ADDR_FALL_EN, ADDR_DEBOUNCE:  d.acc = ACC_RW;
      ADDR_OUT_SET, ADDR_OUT_CLR:   d.acc = ACC_WO;
      ADDR_IN_DATA:                 d.acc = ACC_RO;
      ADDR_IRQ_STATUS:              d.acc = ACC_W1C;
      default:                      d.mapped = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// Slot bus between an MMIO master and the gpio_irq peripheral.
interface gpio_irq_if;
  logic        chip_select;
  logic        read;
  logic        write;
  logic        transaction_completed;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        wr_done;
  logic        rd_done;
  logic        idle;
  logic        slave_error;
  logic        decode_error;

  modport master (
    output chip_select, read, write, transaction_completed, addr, wr_data,
    input  rd_data, wr_done, rd_done, idle, slave_error, decode_error
  );

  modport slave (
    input  chip_select, read, write, transaction_completed, addr, wr_data,
    output rd_data, wr_done, rd_done, idle, slave_error, decode_error
  );
endinterface

// File: rtl/gpio_irq_debounce.sv
// One input pin: 2-flop synchroniser, saturating debounce counter and edge detector.
module gpio_debounce #(
  parameter int unsigned DB_WIDTH = 16
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                pin,
  input  logic [DB_WIDTH-1:0] threshold,
  input  logic                rise_en,
  input  logic                fall_en,
  output logic                stable,
  output logic                edge_evt
);

  logic                sync1_q;
  logic                sync2_q;
  logic                stable_q;
  logic                prev_q;
  logic [DB_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      // threshold is compared live, so a lowered DEBOUNCE takes effect on a running count
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= threshold) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + DB_WIDTH'(1);
      end
    end
  end

  assign stable   = stable_q;
  assign edge_evt = (stable_q & ~prev_q & rise_en) | (~stable_q & prev_q & fall_en);

endmodule

// File: rtl/gpio_irq.sv
// GPIO slot peripheral: output register with set/clear, debounced inputs, edge-latched W1C interrupts.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_INPUT  = 9,
  parameter int unsigned NUM_OUTPUT = 4,
  parameter int unsigned DB_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  gpio_irq_if.slave             bus,
  input  logic [NUM_INPUT-1:0]  in_ports,
  output logic [NUM_OUTPUT-1:0] out_ports,
  output logic                  irq
);

  state_e state_q, state_d;

  logic        req_write_q;
  logic [7:0]  req_addr_q;
  logic [31:0] req_data_q;

  logic [NUM_OUTPUT-1:0] out_q;
  logic [NUM_INPUT-1:0]  irq_en_q, rise_en_q, fall_en_q, status_q, status_d;
  logic [NUM_INPUT-1:0]  in_data, edge_evt;
  logic [DB_WIDTH-1:0]   debounce_q;

  logic [31:0] rd_data_q, rd_mux;
  logic        wr_done_q, rd_done_q, slave_err_q, decode_err_q;

  decode_t dec;
  logic    start, acc_ok, do_wr, do_rd;
  logic    unused_wr_data;

  assign start  = bus.chip_select && (bus.read || bus.write);
  assign dec    = decode_addr(req_addr_q);
  assign acc_ok = dec.mapped && (req_write_q ? (dec.acc != ACC_RO) : (dec.acc != ACC_WO));
  assign do_wr  = (state_q == ACTIVE) && req_write_q && acc_ok;
  assign do_rd  = (state_q == ACTIVE) && !req_write_q && acc_ok;
  assign unused_wr_data = ^req_data_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  state_d = DONE;
      DONE:    if (bus.transaction_completed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (req_addr_q)
      ADDR_OUT_DATA:   rd_mux[NUM_OUTPUT-1:0] = out_q;
      ADDR_IN_DATA:    rd_mux[NUM_INPUT-1:0]  = in_data;
      ADDR_IRQ_EN:     rd_mux[NUM_INPUT-1:0]  = irq_en_q;
      ADDR_RISE_EN:    rd_mux[NUM_INPUT-1:0]  = rise_en_q;
      ADDR_FALL_EN:    rd_mux[NUM_INPUT-1:0]  = fall_en_q;
      ADDR_IRQ_STATUS: rd_mux[NUM_INPUT-1:0]  = status_q;
      ADDR_DEBOUNCE:   rd_mux[DB_WIDTH-1:0]   = debounce_q;
      default:         rd_mux = '0;
    endcase
  end

  // edge events are OR-ed in after the clear so a same-cycle event survives W1C
  always_comb begin
    status_d = status_q;
    if (do_wr && (req_addr_q == ADDR_IRQ_STATUS))
      status_d = status_q & ~req_data_q[NUM_INPUT-1:0];
    status_d = status_d | edge_evt;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      rd_data_q    <= '0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      slave_err_q  <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        req_write_q <= bus.write;
        req_addr_q  <= bus.addr;
        req_data_q  <= bus.wr_data;
      end
      if (state_q == ACTIVE) begin
        wr_done_q    <= req_write_q && acc_ok;
        rd_done_q    <= !req_write_q && acc_ok;
        slave_err_q  <= dec.mapped && !acc_ok;
        decode_err_q <= !dec.mapped;
        if (do_rd) rd_data_q <= rd_mux;
      end else if (state_q == DONE && bus.transaction_completed) begin
        wr_done_q    <= 1'b0;
        rd_done_q    <= 1'b0;
        slave_err_q  <= 1'b0;
        decode_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_q      <= '0;
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      debounce_q <= '0;
      irq        <= 1'b0;
    end else begin
      if (do_wr) begin
        case (req_addr_q)
          ADDR_OUT_DATA: out_q      <= req_data_q[NUM_OUTPUT-1:0];
          ADDR_OUT_SET:  out_q      <= out_q | req_data_q[NUM_OUTPUT-1:0];
          ADDR_OUT_CLR:  out_q      <= out_q & ~req_data_q[NUM_OUTPUT-1:0];
          ADDR_IRQ_EN:   irq_en_q   <= req_data_q[NUM_INPUT-1:0];
          ADDR_RISE_EN:  rise_en_q  <= req_data_q[NUM_INPUT-1:0];
          ADDR_FALL_EN:  fall_en_q  <= req_data_q[NUM_INPUT-1:0];
          ADDR_DEBOUNCE: debounce_q <= req_data_q[DB_WIDTH-1:0];
          default: ;
        endcase
      end
      status_q <= status_d;
      irq      <= |(status_q & irq_en_q);
    end
  end

  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_pin
    gpio_debounce #(.DB_WIDTH(DB_WIDTH)) u_db (
      .clk       (clk),
      .arst      (arst),
      .pin       (in_ports[i]),
      .threshold (debounce_q),
      .rise_en   (rise_en_q[i]),
      .fall_en   (fall_en_q[i]),
      .stable    (in_data[i]),
      .edge_evt  (edge_evt[i])
    );
  end

  assign out_ports        = out_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.slave_error  = slave_err_q;
  assign bus.decode_error = decode_err_q;
  assign bus.idle         = (state_q == IDLE);

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: expected responses queued at request time, popped on response.
module tb_gpio_irq;
  import gpio_irq_pkg::*;

  localparam int unsigned NI  = 9;
  localparam int unsigned NO  = 4;
  localparam int unsigned DBW = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic [NI-1:0] in_ports;
  logic [NO-1:0] out_ports;
  logic          irq;

  gpio_irq_if bus ();

  gpio_irq #(.NUM_INPUT(NI), .NUM_OUTPUT(NO), .DB_WIDTH(DBW)) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr_done;
    logic        rd_done;
    logic        serr;
    logic        derr;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] fl;
  assign fl = {bus.wr_done, bus.rd_done, bus.slave_error, bus.decode_error};

  function automatic exp_t mk(input logic w, input logic r, input logic s, input logic d,
                              input logic c, input logic [31:0] v);
    return {w, r, s, d, c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge with the slot idle.
  task automatic access(input string tag, input logic wr, input logic [7:0] a,
                        input logic [31:0] d, input exp_t e);
    exp_t x;
    int   n = 0;
    bus.chip_select = 1'b1;
    bus.write       = wr;
    bus.read        = !wr;
    bus.addr        = a;
    bus.wr_data     = d;
    sb_q.push_back(e);
    do begin
      @(negedge clk);
      n++;
    end while (fl == 4'b0000 && n < 10);
    chk({tag, ".lat"}, 32'(n), 32'd3);
    x = sb_q.pop_front();
    chk({tag, ".flags"}, 32'(fl), 32'({x.wr_done, x.rd_done, x.serr, x.derr}));
    if (x.chk_data) chk({tag, ".data"}, bus.rd_data, x.data);
    @(negedge clk);
    chk({tag, ".hold"}, 32'(fl), 32'({x.wr_done, x.rd_done, x.serr, x.derr}));
    tick;
    bus.transaction_completed = 1'b1;
    bus.chip_select = 1'b0;
    bus.read        = 1'b0;
    bus.write       = 1'b0;
    tick;
    bus.transaction_completed = 1'b0;
    chk({tag, ".rel"}, 32'({bus.idle, fl}), 32'h10);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d);
    access(tag, 1'b1, a, d, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] v);
    access(tag, 1'b0, a, 32'h0, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    arst = 1'b1;
    in_ports = '0;
    bus.chip_select = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.transaction_completed = 1'b0;
    bus.addr = '0;
    bus.wr_data = '0;
    repeat (3) tick;
    arst = 1'b0;
    @(negedge clk);
    chk("rst.idle_flags", 32'({bus.idle, fl}), 32'h10);
    chk("rst.rd_data", bus.rd_data, 32'h0);
    chk("rst.out_irq", 32'({out_ports, irq}), 32'h0);
    tick;

    // output register with set / clear
    wr("out_wr", ADDR_OUT_DATA, 32'hA);
    chk("out_a", 32'(out_ports), 32'hA);
    rd("out_rd", ADDR_OUT_DATA, 32'h0000000A);
    wr("out_set", ADDR_OUT_SET, 32'h5);
    chk("out_f", 32'(out_ports), 32'hF);
    wr("out_clr", ADDR_OUT_CLR, 32'h3);
    chk("out_c", 32'(out_ports), 32'hC);
    access("rd_wo", 1'b0, ADDR_OUT_SET, 32'h0, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));

    // debounce: short pulse rejected, then exact 13-cycle visibility
    wr("db10", ADDR_DEBOUNCE, 32'd10);
    rd("db_rd", ADDR_DEBOUNCE, 32'd10);
    in_ports[2] = 1'b1;
    repeat (5) tick;
    in_ports[2] = 1'b0;
    repeat (20) tick;
    rd("pulse", ADDR_IN_DATA, 32'h0);
    in_ports[2] = 1'b1;
    repeat (11) tick;
    rd("db_12", ADDR_IN_DATA, 32'h0);
    repeat (20) tick;
    rd("db_hi", ADDR_IN_DATA, 32'h4);
    in_ports[2] = 1'b0;
    repeat (20) tick;
    rd("db_lo", ADDR_IN_DATA, 32'h0);
    in_ports[2] = 1'b1;
    repeat (12) tick;
    rd("db_13", ADDR_IN_DATA, 32'h4);

    // rising-edge interrupt and W1C
    wr("db0", ADDR_DEBOUNCE, 32'd0);
    wr("rise", ADDR_RISE_EN, 32'h1);
    wr("ien", ADDR_IRQ_EN, 32'h1);
    chk("irq_lo", 32'(irq), 32'h0);
    in_ports[0] = 1'b1;
    repeat (6) tick;
    rd("st1", ADDR_IRQ_STATUS, 32'h1);
    chk("irq_hi", 32'(irq), 32'h1);
    wr("w1c", ADDR_IRQ_STATUS, 32'h1);
    chk("irq_clr", 32'(irq), 32'h0);
    rd("st0", ADDR_IRQ_STATUS, 32'h0);

    // edge event on the same clock as the W1C clear
    in_ports[0] = 1'b0;
    repeat (6) tick;
    in_ports[0] = 1'b1;
    repeat (2) tick;
    wr("race_w1c", ADDR_IRQ_STATUS, 32'h1);
    rd("race_st", ADDR_IRQ_STATUS, 32'h1);
    chk("race_irq", 32'(irq), 32'h1);

    // access errors
    access("dec", 1'b0, 8'h40, 32'h0, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    access("wr_ro", 1'b1, ADDR_IN_DATA, 32'hFFFF, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
    rd("in_keep", ADDR_IN_DATA, 32'(in_ports));

    // reset while a read response is held in DONE
    bus.chip_select = 1'b1;
    bus.read = 1'b1;
    bus.addr = ADDR_OUT_DATA;
    repeat (3) @(negedge clk);
    chk("mid.rd", 32'({bus.rd_done, bus.rd_data[3:0]}), 32'h1C);
    #1 arst = 1'b1;
    #1;
    chk("mid.idle_flags", 32'({bus.idle, fl}), 32'h10);
    chk("mid.rd_data", bus.rd_data, 32'h0);
    chk("mid.out_irq", 32'({out_ports, irq}), 32'h0);
    bus.chip_select = 1'b0;
    bus.read = 1'b0;
    tick;
    arst = 1'b0;
    tick;
    rd("post_st", ADDR_IRQ_STATUS, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
